// File: rtl/apb_pkg.sv
// Shared types and defaults for the APB master bridge.
//   Default bus widths, the master FSM state encoding, the host command
//   payload layout and a helper that sizes the transfer-timeout counter.
package apb_pkg;

  localparam int unsigned APB_ADDR_WIDTH  = 32;
  localparam int unsigned APB_DATA_WIDTH  = 32;
  localparam int unsigned APB_PSTRB_WIDTH = APB_DATA_WIDTH / 8;
  localparam int unsigned APB_PROT_WIDTH  = 3;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } apb_mstate_e;

  // Host command payload at the default bus widths.
  typedef struct packed {
    logic                       write;
    logic [APB_ADDR_WIDTH-1:0]  addr;
    logic [APB_DATA_WIDTH-1:0]  wdata;
    logic [APB_PSTRB_WIDTH-1:0] strb;
    logic [APB_PROT_WIDTH-1:0]  prot;
  } apb_cmd_t;

  // Counter must hold the value TIMEOUT_CYCLES itself; keep at least one bit
  // so a disabled timeout (0) still elaborates.
  function automatic int unsigned timeout_cnt_width(input int unsigned cycles);
    return (cycles == 0) ? 1 : $clog2(cycles + 1);
  endfunction

endpackage

// File: rtl/apb_timeout_counter.sv
// ACCESS-phase stall counter for the APB master bridge.
//   clk, rst_n : clock, async active-low reset
//   clear      : zero the count (asserted the cycle before ACCESS starts)
//   enable     : this cycle is an ACCESS cycle with PREADY low
//   expired_c  : this enabled cycle is the TIMEOUT_CYCLES-th stall
// The count saturates at TIMEOUT_CYCLES; with TIMEOUT_CYCLES = 0 the limit is
// already reached at reset, so it never counts and never expires.
module apb_timeout_counter
  import apb_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expired_c
);

  localparam int unsigned CNT_W = timeout_cnt_width(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT_CYCLES);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Next count and expiry strobe.
  always_comb begin
    cnt_d     = cnt_q;
    expired_c = 1'b0;
    if (clear) begin
      cnt_d = '0;
    end else if (enable && (cnt_q != LIMIT)) begin
      cnt_d     = cnt_q + CNT_W'(1);
      expired_c = (cnt_d == LIMIT);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/apb_master_bridge.sv
// APB4 requester: takes one host command at a time, runs SETUP/ACCESS,
// waits on PREADY (bounded by a stall timeout) and returns the result on a
// back-pressured response port.
//   clk, PRESETn                      : clock, async active-low reset
//   cmd_valid/cmd_ready               : command handshake
//   cmd_write/addr/wdata/strb/prot    : command payload
//   rsp_valid/rsp_ready               : response handshake
//   rsp_rdata/rsp_err/rsp_timeout     : response payload
//   PADDR..PSTRB (out), PRDATA/PREADY/PSLVERR (in) : APB bus
module apb_master_bridge
  import apb_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH     = APB_ADDR_WIDTH,
  parameter int unsigned DATA_WIDTH     = APB_DATA_WIDTH,
  parameter int unsigned PSTRB_WIDTH    = DATA_WIDTH / 8,
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic                      clk,
  input  logic                      PRESETn,
  input  logic                      cmd_valid,
  output logic                      cmd_ready,
  input  logic                      cmd_write,
  input  logic [ADDR_WIDTH-1:0]     cmd_addr,
  input  logic [DATA_WIDTH-1:0]     cmd_wdata,
  input  logic [PSTRB_WIDTH-1:0]    cmd_strb,
  input  logic [APB_PROT_WIDTH-1:0] cmd_prot,
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic [DATA_WIDTH-1:0]     rsp_rdata,
  output logic                      rsp_err,
  output logic                      rsp_timeout,
  output logic [ADDR_WIDTH-1:0]     PADDR,
  output logic [APB_PROT_WIDTH-1:0] PPROT,
  output logic                      PSELx,
  output logic                      PENABLE,
  output logic                      PWRITE,
  output logic [DATA_WIDTH-1:0]     PWDATA,
  output logic [PSTRB_WIDTH-1:0]    PSTRB,
  input  logic [DATA_WIDTH-1:0]     PRDATA,
  input  logic                      PREADY,
  input  logic                      PSLVERR
);

  if (!((DATA_WIDTH == 8) || (DATA_WIDTH == 16) || (DATA_WIDTH == 32)))
  begin : g_bad_data_width
    $error("apb_master_bridge: DATA_WIDTH must be 8, 16 or 32");
  end
  if (PSTRB_WIDTH != DATA_WIDTH / 8) begin : g_bad_strb_width
    $error("apb_master_bridge: PSTRB_WIDTH must be DATA_WIDTH/8");
  end

  apb_mstate_e state_q, state_d;

  logic                      cmd_ready_q,   cmd_ready_d;
  logic                      psel_q,        psel_d;
  logic                      penable_q,     penable_d;
  logic                      pwrite_q,      pwrite_d;
  logic [ADDR_WIDTH-1:0]     paddr_q,       paddr_d;
  logic [DATA_WIDTH-1:0]     pwdata_q,      pwdata_d;
  logic [PSTRB_WIDTH-1:0]    pstrb_q,       pstrb_d;
  logic [APB_PROT_WIDTH-1:0] pprot_q,       pprot_d;
  logic                      rsp_valid_q,   rsp_valid_d;
  logic [DATA_WIDTH-1:0]     rsp_rdata_q,   rsp_rdata_d;
  logic                      rsp_err_q,     rsp_err_d;
  logic                      rsp_timeout_q, rsp_timeout_d;

  logic cnt_clear_c, cnt_enable_c, expired_c;

  // Stall counter restarts while in SETUP and counts ACCESS cycles without PREADY.
  assign cnt_clear_c  = (state_q == SETUP);
  assign cnt_enable_c = (state_q == ACCESS) && !PREADY;

  apb_timeout_counter #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_timeout (
    .clk       (clk),
    .rst_n     (PRESETn),
    .clear     (cnt_clear_c),
    .enable    (cnt_enable_c),
    .expired_c (expired_c)
  );

  // Next state, request capture and response capture.
  // Bus and handshake flops are loaded from the next state so they line up
  // with the state they describe.
  always_comb begin
    state_d       = state_q;
    pwrite_d      = pwrite_q;
    paddr_d       = paddr_q;
    pwdata_d      = pwdata_q;
    pstrb_d       = pstrb_q;
    pprot_d       = pprot_q;
    rsp_rdata_d   = rsp_rdata_q;
    rsp_err_d     = rsp_err_q;
    rsp_timeout_d = rsp_timeout_q;

    unique case (state_q)
      IDLE: begin
        if (cmd_valid && cmd_ready_q) begin
          state_d  = SETUP;
          pwrite_d = cmd_write;
          paddr_d  = cmd_addr;
          pwdata_d = cmd_wdata;
          // Reads never drive strobes; write strobes pass through as given.
          pstrb_d  = cmd_write ? cmd_strb : '0;
          pprot_d  = cmd_prot;
        end
      end
      SETUP: begin
        state_d = ACCESS;
      end
      ACCESS: begin
        // PREADY takes priority: expiry is only possible with PREADY low.
        if (PREADY) begin
          state_d       = RESP;
          rsp_rdata_d   = pwrite_q ? '0 : PRDATA;
          rsp_err_d     = PSLVERR;
          rsp_timeout_d = 1'b0;
        end else if (expired_c) begin
          state_d       = RESP;
          rsp_rdata_d   = '0;
          rsp_err_d     = 1'b1;
          rsp_timeout_d = 1'b1;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    cmd_ready_d = (state_d == IDLE);
    psel_d      = (state_d == SETUP) || (state_d == ACCESS);
    penable_d   = (state_d == ACCESS);
    rsp_valid_d = (state_d == RESP);
  end

  always_ff @(posedge clk or negedge PRESETn) begin
    if (!PRESETn) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or negedge PRESETn) begin
    if (!PRESETn) begin
      cmd_ready_q   <= 1'b0;
      psel_q        <= 1'b0;
      penable_q     <= 1'b0;
      pwrite_q      <= 1'b0;
      paddr_q       <= '0;
      pwdata_q      <= '0;
      pstrb_q       <= '0;
      pprot_q       <= '0;
      rsp_valid_q   <= 1'b0;
      rsp_rdata_q   <= '0;
      rsp_err_q     <= 1'b0;
      rsp_timeout_q <= 1'b0;
    end else begin
      cmd_ready_q   <= cmd_ready_d;
      psel_q        <= psel_d;
      penable_q     <= penable_d;
      pwrite_q      <= pwrite_d;
      paddr_q       <= paddr_d;
      pwdata_q      <= pwdata_d;
      pstrb_q       <= pstrb_d;
      pprot_q       <= pprot_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_rdata_q   <= rsp_rdata_d;
      rsp_err_q     <= rsp_err_d;
      rsp_timeout_q <= rsp_timeout_d;
    end
  end

  assign cmd_ready   = cmd_ready_q;
  assign PSELx       = psel_q;
  assign PENABLE     = penable_q;
  assign PWRITE      = pwrite_q;
  assign PADDR       = paddr_q;
  assign PWDATA      = pwdata_q;
  assign PSTRB       = pstrb_q;
  assign PPROT       = pprot_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_rdata   = rsp_rdata_q;
  assign rsp_err     = rsp_err_q;
  assign rsp_timeout = rsp_timeout_q;

endmodule

// File: tb/tb_apb_master_bridge.sv
// Directed bench for apb_master_bridge with an 8-cycle stall timeout and a
// simple wait-state slave model.
module tb_apb_master_bridge;

  logic        clk = 1'b0;
  logic        PRESETn;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [31:0] cmd_addr, cmd_wdata;
  logic [3:0]  cmd_strb;
  logic [2:0]  cmd_prot;
  logic        rsp_valid, rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err, rsp_timeout;
  logic [31:0] PADDR, PWDATA, PRDATA;
  logic [2:0]  PPROT;
  logic        PSELx, PENABLE, PWRITE, PREADY, PSLVERR;
  logic [3:0]  PSTRB;

  // Slave model configuration.
  int          ws_cfg;
  int          ws_cnt;
  logic        stuck;
  logic [31:0] rd_data;
  logic        slverr;

  int n_tests = 0;
  int n_fail  = 0;

  apb_master_bridge #(
    .ADDR_WIDTH     (32),
    .DATA_WIDTH     (32),
    .PSTRB_WIDTH    (4),
    .TIMEOUT_CYCLES (8)
  ) dut (
    .clk         (clk),
    .PRESETn     (PRESETn),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_write   (cmd_write),
    .cmd_addr    (cmd_addr),
    .cmd_wdata   (cmd_wdata),
    .cmd_strb    (cmd_strb),
    .cmd_prot    (cmd_prot),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_rdata   (rsp_rdata),
    .rsp_err     (rsp_err),
    .rsp_timeout (rsp_timeout),
    .PADDR       (PADDR),
    .PPROT       (PPROT),
    .PSELx       (PSELx),
    .PENABLE     (PENABLE),
    .PWRITE      (PWRITE),
    .PWDATA      (PWDATA),
    .PSTRB       (PSTRB),
    .PRDATA      (PRDATA),
    .PREADY      (PREADY),
    .PSLVERR     (PSLVERR)
  );

  always #5 clk = ~clk;

  // Slave: PREADY after ws_cfg stalled ACCESS cycles, never when stuck.
  always @(posedge clk) begin
    if (PSELx && PENABLE && !PREADY) ws_cnt <= ws_cnt + 1;
    else                             ws_cnt <= 0;
  end
  assign PREADY  = PSELx && PENABLE && !stuck && (ws_cnt == ws_cfg);
  assign PRDATA  = rd_data;
  assign PSLVERR = slverr;

  typedef struct {
    logic        write;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  strb;
    logic [2:0]  prot;
    int          ws;
    logic        stuck;
    logic [31:0] prdata;
    logic        slverr;
    logic [31:0] exp_rdata;
    logic        exp_err;
    logic        exp_to;
    logic [3:0]  exp_pstrb;
    int          exp_lat;   // accept edge to first rsp_valid cycle
    int          exp_pen;   // cycles with PENABLE high
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present a command, wait (bounded) for cmd_ready, complete the handshake.
  task automatic send_cmd(input string tag, input logic w, input logic [31:0] a,
                          input logic [31:0] d, input logic [3:0] s, input logic [2:0] p);
    int n;
    cmd_write = w; cmd_addr = a; cmd_wdata = d; cmd_strb = s; cmd_prot = p;
    cmd_valid = 1'b1;
    n = 0;
    while (!cmd_ready && n < 20) begin
      step();
      n++;
    end
    chk({tag, " accept"}, 32'(cmd_ready), 32'd1);
    step();
    cmd_valid = 1'b0;
  endtask

  task automatic wait_rsp(input string tag);
    int n;
    n = 0;
    while (!rsp_valid && n < 40) begin
      step();
      n++;
    end
    chk({tag, " rsp_valid"}, 32'(rsp_valid), 32'd1);
  endtask

  task automatic take_rsp(input string tag);
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    chk({tag, " rsp_valid drop"}, 32'(rsp_valid), 32'd0);
    chk({tag, " cmd_ready back"}, 32'(cmd_ready), 32'd1);
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    string       tag;
    int          k, setup_cnt, pen_cnt, bad_req;
    logic [31:0] paddr_s, pwdata_s;
    logic [2:0]  pprot_s;
    logic        pwrite_s;
    tag = $sformatf("v%0d", idx);
    ws_cfg = v.ws; stuck = v.stuck; rd_data = v.prdata; slverr = v.slverr;
    send_cmd(tag, v.write, v.addr, v.wdata, v.strb, v.prot);
    k = 1; setup_cnt = 0; pen_cnt = 0; bad_req = 0;
    paddr_s = '0; pwdata_s = '0; pprot_s = '0; pwrite_s = 1'b0;
    while (!rsp_valid && k < 40) begin
      if (PSELx && !PENABLE) setup_cnt++;
      if (PSELx && PENABLE)  pen_cnt++;
      if (k == 1) begin
        paddr_s = PADDR; pwdata_s = PWDATA; pprot_s = PPROT; pwrite_s = PWRITE;
      end
      if (PSELx && ((PADDR !== v.addr) || (PSTRB !== v.exp_pstrb) || (PWRITE !== v.write)))
        bad_req++;
      step();
      k++;
    end
    chk({tag, " latency"},     32'(k),           32'(v.exp_lat));
    chk({tag, " setup cycles"},32'(setup_cnt),   32'd1);
    chk({tag, " access cycles"},32'(pen_cnt),    32'(v.exp_pen));
    chk({tag, " PADDR"},       paddr_s,          v.addr);
    chk({tag, " PWRITE"},      32'(pwrite_s),    32'(v.write));
    chk({tag, " PPROT"},       32'(pprot_s),     32'(v.prot));
    if (v.write) chk({tag, " PWDATA"}, pwdata_s, v.wdata);
    chk({tag, " req stable/PSTRB"}, 32'(bad_req), 32'd0);
    chk({tag, " rsp_rdata"},   rsp_rdata,        v.exp_rdata);
    chk({tag, " rsp_err"},     32'(rsp_err),     32'(v.exp_err));
    chk({tag, " rsp_timeout"}, 32'(rsp_timeout), 32'(v.exp_to));
    chk({tag, " PSELx in RESP"}, 32'(PSELx),     32'd0);
    take_rsp(tag);
    stuck = 1'b0;
  endtask

  initial begin
    logic [31:0] held;

    //            wr addr      wdata         strb  prot ws stk prdata        err exp_rdata     eE eT pstrb lat pen
    vecs[0] = '{1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 3'd0, 0, 1'b0, 32'hFFFF_FFFF, 1'b0, 32'h0,        1'b0, 1'b0, 4'hF, 3,  1};
    vecs[1] = '{1'b0, 32'h14, 32'h0,        4'hF, 3'd2, 3, 1'b0, 32'h1234_5678, 1'b0, 32'h1234_5678,1'b0, 1'b0, 4'h0, 6,  4};
    vecs[2] = '{1'b1, 32'h20, 32'h0000_00A5,4'h3, 3'd1, 1, 1'b0, 32'hFFFF_FFFF, 1'b1, 32'h0,        1'b1, 1'b0, 4'h3, 4,  2};
    vecs[3] = '{1'b0, 32'h24, 32'h0,        4'hF, 3'd0, 0, 1'b1, 32'hAAAA_5555, 1'b0, 32'h0,        1'b1, 1'b1, 4'h0, 10, 8};
    vecs[4] = '{1'b1, 32'h28, 32'hCAFE_0001,4'h0, 3'd7, 2, 1'b0, 32'h0,         1'b0, 32'h0,        1'b0, 1'b0, 4'h0, 5,  3};
    vecs[5] = '{1'b0, 32'h2C, 32'h0,        4'h0, 3'd4, 7, 1'b0, 32'hCAFE_F00D, 1'b0, 32'hCAFE_F00D,1'b0, 1'b0, 4'h0, 10, 8};
    vecs[6] = '{1'b0, 32'h30, 32'h0,        4'h0, 3'd0, 0, 1'b0, 32'h0BAD_F00D, 1'b1, 32'h0BAD_F00D,1'b1, 1'b0, 4'h0, 3,  1};

    PRESETn = 1'b0;
    cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0;
    cmd_strb = '0; cmd_prot = '0; rsp_ready = 1'b0;
    ws_cfg = 0; stuck = 1'b0; rd_data = '0; slverr = 1'b0;

    // Reset state.
    step(); step();
    chk("rst cmd_ready", 32'(cmd_ready), 32'd0);
    chk("rst PSELx",     32'(PSELx),     32'd0);
    chk("rst PENABLE",   32'(PENABLE),   32'd0);
    chk("rst rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst PADDR",     PADDR,          32'd0);
    chk("rst rsp_rdata", rsp_rdata,      32'd0);
    PRESETn = 1'b1;
    step();
    chk("post-rst cmd_ready", 32'(cmd_ready), 32'd1);

    for (int i = 0; i < 7; i++) run_vec(vecs[i], i);

    // Response back-pressure with a new command waiting.
    ws_cfg = 0; rd_data = 32'h55AA_33CC; slverr = 1'b0;
    send_cmd("bp", 1'b0, 32'h34, 32'h0, 4'h0, 3'd0);
    wait_rsp("bp");
    held = rsp_rdata;
    chk("bp rdata", held, 32'h55AA_33CC);
    rd_data = 32'h0;
    cmd_write = 1'b1; cmd_addr = 32'h40; cmd_wdata = 32'h11; cmd_strb = 4'hF;
    cmd_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      chk($sformatf("bp%0d cmd_ready", i), 32'(cmd_ready), 32'd0);
      chk($sformatf("bp%0d PSELx", i),     32'(PSELx),     32'd0);
      chk($sformatf("bp%0d rsp_valid", i), 32'(rsp_valid), 32'd1);
      chk($sformatf("bp%0d rsp_rdata", i), rsp_rdata,      32'h55AA_33CC);
    end
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    chk("bp released cmd_ready", 32'(cmd_ready), 32'd1);
    step();
    cmd_valid = 1'b0;
    chk("bp next SETUP PSELx",   32'(PSELx),   32'd1);
    chk("bp next SETUP PENABLE", 32'(PENABLE), 32'd0);
    chk("bp next PADDR",         PADDR,        32'h40);
    wait_rsp("bp next");
    chk("bp next rsp_err",   32'(rsp_err), 32'd0);
    chk("bp next rsp_rdata", rsp_rdata,    32'd0);
    take_rsp("bp next");

    // Reset asserted during ACCESS.
    stuck = 1'b1;
    send_cmd("rstx", 1'b0, 32'h50, 32'h0, 4'h0, 3'd0);
    step();
    chk("rstx in ACCESS", 32'(PENABLE), 32'd1);
    PRESETn = 1'b0;
    #1;
    chk("rstx PSELx drop",   32'(PSELx),     32'd0);
    chk("rstx PENABLE drop", 32'(PENABLE),   32'd0);
    chk("rstx cmd_ready",    32'(cmd_ready), 32'd0);
    stuck = 1'b0;
    step();
    PRESETn = 1'b1;
    step();
    chk("rstx idle cmd_ready", 32'(cmd_ready), 32'd1);
    chk("rstx idle PSELx",     32'(PSELx),     32'd0);
    chk("rstx idle rsp_valid", 32'(rsp_valid), 32'd0);
    run_vec(vecs[0], 7);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
